// File: rtl/point_reduce_pkg.sv
// Shared constants and state encoding for the ed25519 coordinate reducer.
// Field modulus is q = 2^255 - 19; inputs are double-width products.
package point_reduce_pkg;
    localparam int B    = 256;
    localparam int W2   = 2 * B;
    localparam int FOLD_POS = 255;
    localparam int C19  = 19;
    localparam logic [B-1:0] Q =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FOLD1 = 3'd1,
        FOLD2 = 3'd2,
        CSUB  = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/point_reduce_if.sv
// Start/done handshake plus coordinate buses between point_add and the reducer.
// The reducer sits on the slave side.
interface point_reduce_if;
    import point_reduce_pkg::*;

    logic          enable;
    logic          ready;
    logic          done;
    logic [W2-1:0] x_in, y_in, z_in, t_in;
    logic [B-1:0]  x_out, y_out, z_out, t_out;

    modport master (
        output enable, x_in, y_in, z_in, t_in,
        input  ready, done, x_out, y_out, z_out, t_out
    );

    modport slave (
        input  enable, x_in, y_in, z_in, t_in,
        output ready, done, x_out, y_out, z_out, t_out
    );
endinterface

// File: rtl/point_reduce_fold19.sv
// Combinational fold: lo(in[254:0]) + 19 * in[IN_W-1:255], using 2^255 == 19 mod q.
// Output is sized to hold the full sum without truncation.
module point_reduce_fold19
    import point_reduce_pkg::*;
#(
    parameter int IN_W  = 512,
    parameter int OUT_W = (((IN_W - FOLD_POS + 5) > FOLD_POS) ?
                           (IN_W - FOLD_POS + 5) : FOLD_POS) + 1
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);
    logic [OUT_W-1:0] lo_e;
    logic [OUT_W-1:0] hi_e;

    always_comb begin
        lo_e = OUT_W'(in[FOLD_POS-1:0]);
        hi_e = OUT_W'(in[IN_W-1:FOLD_POS]);
        // 19*hi as shift-and-add: 16*hi + 2*hi + hi
        out  = lo_e + (hi_e << 4) + (hi_e << 1) + hi_e;
    end
endmodule

// File: rtl/point_reduce.sv
// Serial reducer: folds each of x, y, z, t modulo q = 2^255-19 in three
// cycles (FOLD1, FOLD2, CSUB) and pulses done once all four are written.
module point_reduce
    import point_reduce_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    point_reduce_if.slave  bus
);
    localparam int F1_W = 263;
    localparam int F2_W = 256;

    state_t        state_q, state_d;
    logic [1:0]    idx;
    logic [W2-1:0] coord [4];
    logic [W2-1:0] v;
    logic [B-1:0]  res [4];

    logic [F1_W-1:0] f1_out;
    logic [F2_W-1:0] f2_out;
    logic [B-1:0]    vs;
    logic [B-1:0]    red;

    point_reduce_fold19 #(.IN_W(W2),   .OUT_W(F1_W)) u_fold1 (.in(v),            .out(f1_out));
    point_reduce_fold19 #(.IN_W(F1_W), .OUT_W(F2_W)) u_fold2 (.in(v[F1_W-1:0]),  .out(f2_out));

    // After FOLD2 the value is below 2q, so one conditional subtract is canonical
    always_comb begin
        vs  = v[B-1:0];
        red = (vs >= Q) ? (vs - Q) : vs;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable) state_d = FOLD1;
            FOLD1:   state_d = FOLD2;
            FOLD2:   state_d = CSUB;
            CSUB:    state_d = (idx == 2'd3) ? DONE : FOLD1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx     <= 2'd0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.enable) idx <= 2'd0;
                CSUB: begin
                    res[idx] <= red;
                    if (idx != 2'd3) idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Working register is loaded with the next coordinate as each CSUB retires
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: if (bus.enable) begin
                coord[0] <= bus.x_in;
                coord[1] <= bus.y_in;
                coord[2] <= bus.z_in;
                coord[3] <= bus.t_in;
                v        <= bus.x_in;
            end
            FOLD1: v <= W2'(f1_out);
            FOLD2: v <= W2'(f2_out);
            CSUB:  if (idx != 2'd3) v <= coord[idx + 2'd1];
            default: ;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.x_out = res[0];
    assign bus.y_out = res[1];
    assign bus.z_out = res[2];
    assign bus.t_out = res[3];
endmodule

// File: tb/tb_point_reduce.sv
// Bench for point_reduce: directed boundary runs, mid-run reset, held enable,
// and randomized vectors checked against a plain modulo reference.
module tb_point_reduce;
    import point_reduce_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passes = 0;

    point_reduce_if pif ();

    point_reduce dut (
        .clk (clk),
        .rst (rst),
        .bus (pif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [B-1:0] ref_mod(input logic [W2-1:0] a);
        logic [W2-1:0] r;
        r = a % {{B{1'b0}}, Q};
        return r[B-1:0];
    endfunction

    function automatic logic [W2-1:0] rand512();
        logic [W2-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[W2-33:0], 32'($urandom)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic [B-1:0] ex, ey, ez, et);
        chk({tag, "_x"}, W2'(pif.x_out), W2'(ex));
        chk({tag, "_y"}, W2'(pif.y_out), W2'(ey));
        chk({tag, "_z"}, W2'(pif.z_out), W2'(ez));
        chk({tag, "_t"}, W2'(pif.t_out), W2'(et));
    endtask

    task automatic run(input string tag, input logic [W2-1:0] a, b, c, d,
                       input logic [B-1:0] ea, eb, ec, ed);
        int cycles;
        @(negedge clk);
        pif.x_in = a; pif.y_in = b; pif.z_in = c; pif.t_in = d;
        pif.enable = 1'b1;
        @(negedge clk);
        pif.enable = 1'b0;
        chk({tag, "_busy"}, W2'(pif.ready), W2'(0));
        cycles = 0;
        while (!pif.done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_latency"}, W2'(cycles), W2'(12));
        chk_outs(tag, ea, eb, ec, ed);
        @(negedge clk);
        chk({tag, "_done_once"}, W2'(pif.done), W2'(0));
        chk({tag, "_ready"}, W2'(pif.ready), W2'(1));
    endtask

    initial begin
        logic [W2-1:0] qq, a, b, c, d;
        int ndone, first, second, cycles;
        qq = {{B{1'b0}}, Q};
        rst = 1'b1;
        pif.enable = 1'b0;
        pif.x_in = '0; pif.y_in = '0; pif.z_in = '0; pif.t_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", W2'(pif.ready), W2'(1));
        chk("reset_done", W2'(pif.done), W2'(0));
        chk_outs("reset", '0, '0, '0, '0);

        run("small", 3, 5, 7, 9, 3, 5, 7, 9);
        run("bound_q", qq, qq + 5, 2 * qq - 1, 0, 0, 5, Q - 1, 0);
        a = '0; a[511] = 1'b1;
        c = '0; c[255] = 1'b1;
        run("bound_pow", a, '1, c, c + 18, 722, 1443, 19, 37);

        // Reset while y is in FOLD2 (four edges after acceptance)
        @(negedge clk);
        pif.x_in = 100; pif.y_in = 200; pif.z_in = 300; pif.t_in = 400;
        pif.enable = 1'b1;
        @(negedge clk);
        pif.enable = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", W2'(pif.ready), W2'(1));
        chk("midrst_done", W2'(pif.done), W2'(0));
        chk_outs("midrst", '0, '0, '0, '0);
        run("after_rst", 4, 11, qq + 2, 1, 4, 11, 2, 1);

        // Enable held for 30 cycles: accepts only when idle
        @(negedge clk);
        pif.x_in = 6; pif.y_in = 8; pif.z_in = 10; pif.t_in = 12;
        pif.enable = 1'b1;
        ndone = 0; first = -1; second = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pif.done) begin
                ndone++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
                chk_outs("held", 6, 8, 10, 12);
            end
        end
        pif.enable = 1'b0;
        chk("held_count", W2'(ndone), W2'(2));
        chk("held_first", W2'(first), W2'(12));
        chk("held_gap", W2'(second - first), W2'(14));
        cycles = 0;
        while (!pif.done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk("held_third_done", W2'(pif.done), W2'(1));
        chk_outs("held_third", 6, 8, 10, 12);
        @(negedge clk);
        chk("held_idle", W2'(pif.ready), W2'(1));

        for (int n = 0; n < 1000; n++) begin
            a = rand512(); b = rand512(); c = rand512(); d = rand512();
            case (n % 4)
                1: begin a = a & {{249{1'b0}}, {263{1'b1}}}; b = b >> 250; end
                2: begin a = qq * 512'($urandom_range(0, 7)) + 512'($urandom_range(0, 40));
                         c = qq - 512'($urandom_range(0, 3)); end
                3: begin b = '1 - 512'($urandom_range(0, 100)); d = qq * 2 - 1; end
                default: ;
            endcase
            run("rand", a, b, c, d, ref_mod(a), ref_mod(b), ref_mod(c), ref_mod(d));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
